// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a length-prefixed program from the host into instruction memory, then enables the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing mod-2^DATA_W sum word before the CPU is released.
module prog_loader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_req,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_adrs,
  output logic [DATA_W-1:0] w_instruction,
  output logic              cpu_en,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_RUN,
    S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              w_enable_q, w_enable_d;
  logic [ADDR_W-1:0] w_adrs_q, w_adrs_d;
  logic [DATA_W-1:0] w_instruction_q, w_instruction_d;
  logic              cpu_en_q, cpu_en_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  logic [ADDR_W:0] hdr_len;
  logic            hdr_bad;
  logic [ADDR_W:0] cnt_inc;

  // A header is legal only for 1..2^ADDR_W words.
  assign hdr_len = s_data[ADDR_W:0];
  assign hdr_bad = (hdr_len == '0) || (hdr_len[ADDR_W] && (|hdr_len[ADDR_W-1:0]));
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    w_enable_d      = 1'b0;
    w_adrs_d        = w_adrs_q;
    w_instruction_d = w_instruction_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d           = sum_q;
`endif
    s_ready         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_req) state_d = S_HDR;
      end
      S_HDR: begin
        s_ready = 1'b1;
        if (s_valid) begin
          len_d   = hdr_len;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = hdr_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_enable_d      = 1'b1;
          w_adrs_d        = cnt_q[ADDR_W-1:0];
          w_instruction_d = s_data;
          cnt_d           = cnt_inc;
`ifdef LOADER_CHECKSUM_EN
          sum_d           = sum_q + s_data;
          if (cnt_inc == len_q) state_d = S_CHK;
`else
          if (cnt_inc == len_q) state_d = S_RUN;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        s_ready = 1'b1;
        if (s_valid) state_d = (s_data == sum_q) ? S_RUN : S_ERR;
      end
`endif
      S_RUN: begin
        if (load_req) state_d = S_HDR;
      end
      S_ERR: begin
        if (load_req) state_d = S_HDR;
      end
      default: state_d = S_IDLE;
    endcase

    // Lagging the state by one edge puts cpu_en after the final write strobe.
    cpu_en_d = (state_q == S_RUN) && !load_req;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      len_q           <= '0;
      cnt_q           <= '0;
      w_enable_q      <= 1'b0;
      w_adrs_q        <= '0;
      w_instruction_q <= '0;
      cpu_en_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      w_enable_q      <= w_enable_d;
      w_adrs_q        <= w_adrs_d;
      w_instruction_q <= w_instruction_d;
      cpu_en_q        <= cpu_en_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q           <= sum_d;
`endif
    end
  end

  assign w_enable      = w_enable_q;
  assign w_adrs        = w_adrs_q;
  assign w_instruction = w_instruction_q;
  assign cpu_en        = cpu_en_q;
`ifdef LOADER_CHECKSUM_EN
  assign busy          = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
`else
  assign busy          = (state_q == S_HDR) || (state_q == S_DATA);
`endif
  assign err           = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader; honours LOADER_CHECKSUM_EN when defined.
module tb_prog_loader;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          load_req = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          w_enable;
  logic [AW-1:0] w_adrs;
  logic [DW-1:0] w_instruction;
  logic          cpu_en;
  logic          busy;
  logic          err;

  prog_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn), .load_req(load_req), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .w_enable(w_enable), .w_adrs(w_adrs), .w_instruction(w_instruction),
    .cpu_en(cpu_en), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [DW-1:0] wbuf[0:2047];
  bit            toggle_mode = 1'b0;
  bit            noise_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every accepted data word must appear as exactly one write in the following cycle.
  always @(negedge clk) begin
    if (w_enable || exp_q.size() > 0) begin
      checks++;
      if (!w_enable) begin
        errors++;
        mon_e = exp_q.pop_front();
        $display("FAIL write_missing: got no strobe expected adr=%0d data=0x%h", mon_e.adr, mon_e.dat);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_spurious: got adr=%0d data=0x%h expected no write", w_adrs, w_instruction);
      end else begin
        mon_e = exp_q.pop_front();
        if (w_adrs !== mon_e.adr || w_instruction !== mon_e.dat || cpu_en !== 1'b0) begin
          errors++;
          $display("FAIL write_data: got adr=%0d data=0x%h cpu_en=%0b expected adr=%0d data=0x%h cpu_en=0",
                   w_adrs, w_instruction, cpu_en, mon_e.adr, mon_e.dat);
        end
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      s_valid  = 1'b0;
      s_data   = $urandom;
      load_req = noise_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    load_req = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit is_data, input int adr);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    if (toggle_mode) gap(1);
    else gap($urandom_range(0, 2));
    s_valid = 1'b1;
    s_data  = d;
    while (!acc && guard < 50) begin
      acc = s_ready;
      @(posedge clk);
      guard++;
      if (acc && is_data) exp_q.push_back({adr[AW-1:0], d});
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic do_load(input int len, input bit tog, input bit noise, input bit bad_sum,
                         input logic [DW-1:0] hdr_hi);
    logic [DW-1:0] sum;
    sum         = '0;
    toggle_mode = tog;
    noise_mode  = noise;
    send(hdr_hi | DW'(len), 1'b0, 0);
    for (int i = 0; i < len; i++) begin
      send(wbuf[i], 1'b1, i);
      sum = sum + wbuf[i];
      if (i < 3 || i == len - 1) check("cpu_en_during_load", 64'(cpu_en), 64'd0);
    end
`ifdef LOADER_CHECKSUM_EN
    send(bad_sum ? sum - 1 : sum, 1'b0, 0);
    if (bad_sum) begin
      check("bad_sum_err", 64'(err), 64'd1);
      check("bad_sum_cpu_en", 64'(cpu_en), 64'd0);
      return;
    end
    check("cpu_en_after_trailer", 64'(cpu_en), 64'd0);
`else
    if (bad_sum) check("bad_sum_unsupported", 64'd0, 64'(sum == sum));
`endif
    @(negedge clk);
    check("cpu_en_run", 64'(cpu_en), 64'd1);
    check("busy_run", 64'(busy), 64'd0);
    check("s_ready_run", 64'(s_ready), 64'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_w_enable", 64'(w_enable), 64'd0);
    check("rst_w_adrs", 64'(w_adrs), 64'd0);
    check("rst_w_instruction", 64'(w_instruction), 64'd0);
    check("rst_cpu_en", 64'(cpu_en), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    s_valid = 1'b1;
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
    check("idle_busy", 64'(busy), 64'd0);

    // Basic three-word program.
    pulse_load();
    check("hdr_busy", 64'(busy), 64'd1);
    wbuf[0] = 32'hE; wbuf[1] = 32'hF; wbuf[2] = 32'h0;
    do_load(3, 1'b0, 1'b0, 1'b0, '0);

    // Reload from RUN.
    pulse_load();
    check("reload_cpu_en_drop", 64'(cpu_en), 64'd0);
    check("reload_busy", 64'(busy), 64'd1);
    wbuf[0] = 32'hFFFF_FFFF;
    do_load(1, 1'b0, 1'b0, 1'b0, '0);

    // Same program with s_valid toggling.
    pulse_load();
    wbuf[0] = 32'hE; wbuf[1] = 32'hF; wbuf[2] = 32'h0;
    do_load(3, 1'b1, 1'b0, 1'b0, '0);

    // Illegal headers.
    pulse_load();
    toggle_mode = 1'b0; noise_mode = 1'b0;
    send(32'h0, 1'b0, 0);
    check("hdr0_err", 64'(err), 64'd1);
    check("hdr0_cpu_en", 64'(cpu_en), 64'd0);
    check("hdr0_s_ready", 64'(s_ready), 64'd0);
    pulse_load();
    check("err_cleared", 64'(err), 64'd0);
    send(32'h801, 1'b0, 0);
    check("hdr801_err", 64'(err), 64'd1);
    check("hdr801_cpu_en", 64'(cpu_en), 64'd0);

    // Largest legal program, entered from ERR.
    pulse_load();
    for (int i = 0; i < 2048; i++) wbuf[i] = $urandom;
    do_load(2048, 1'b0, 1'b0, 1'b0, '0);

`ifdef LOADER_CHECKSUM_EN
    pulse_load();
    wbuf[0] = 32'hE; wbuf[1] = 32'hF;
    do_load(2, 1'b0, 1'b0, 1'b0, '0);
    pulse_load();
    do_load(2, 1'b0, 1'b0, 1'b1, '0);
`endif

    // Randomized loads: header high bits are junk, load_req noise during gaps.
    for (int n = 0; n < 10; n++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) wbuf[i] = $urandom;
      pulse_load();
      do_load(len, 1'($urandom_range(0, 1)), 1'b1, 1'b0, $urandom & 32'hFFFF_F000);
    end

    // Reset after two of three data words.
    pulse_load();
    toggle_mode = 1'b0; noise_mode = 1'b0;
    wbuf[0] = $urandom; wbuf[1] = $urandom;
    send(32'd3, 1'b0, 0);
    send(wbuf[0], 1'b1, 0);
    send(wbuf[1], 1'b1, 1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("abort_w_enable", 64'(w_enable), 64'd0);
    check("abort_w_adrs", 64'(w_adrs), 64'd0);
    check("abort_w_instruction", 64'(w_instruction), 64'd0);
    check("abort_cpu_en", 64'(cpu_en), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_pending", 64'(exp_q.size()), 64'd0);
    s_valid = 1'b1; s_data = $urandom;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
    check("abort_idle_s_ready", 64'(s_ready), 64'd0);
    check("abort_idle_busy", 64'(busy), 64'd0);
    check("abort_idle_err", 64'(err), 64'd0);

    // Recovery load after reset.
    pulse_load();
    wbuf[0] = 32'h1234_5678; wbuf[1] = 32'h9ABC_DEF0;
    do_load(2, 1'b0, 1'b0, 1'b0, '0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 11, width of the instruction-memory write address.
REQ-002 Parameter DATA_W, default 32, width of host data and instruction words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 load_req  input  1  one-cycle pulse requesting a (re)load of the program.
REQ-006 s_valid  input  1  host word valid.
REQ-007 s_data  input  DATA_W  host word.
REQ-008 s_ready  output  1  loader accepts a word; transfer occurs when s_valid and s_ready are both high at a rising edge.
REQ-009 w_enable  output  1  instruction-memory write strobe, registered.
REQ-010 w_adrs  output  ADDR_W  instruction-memory write address, registered.
REQ-011 w_instruction  output  DATA_W  instruction-memory write data, registered.
REQ-012 cpu_en  output  1  CPU run enable, registered.
REQ-013 busy  output  1  high in HDR, DATA or CHK.
REQ-014 err  output  1  high in ERR.

Function
REQ-015 The FSM SHALL have states IDLE, HDR, DATA, CHK, RUN and ERR.
REQ-016 IDLE: s_ready=0, cpu_en=0; a load_req SHALL move the FSM to HDR.
REQ-017 HDR: s_ready=1; an accepted word SHALL set len = s_data[ADDR_W:0], clear the word counter and the checksum, then go to DATA.
REQ-018 HDR: len=0 or len>2^ADDR_W SHALL move the FSM to ERR.
REQ-019 DATA: s_ready=1; each accepted word SHALL drive w_enable=1, w_adrs=counter and w_instruction=s_data in the following cycle only, then increment the counter.
REQ-020 Write addresses SHALL run 0..len-1 in order, with no gaps and no writes outside that range.
REQ-021 When the len-th word is accepted at edge k, the FSM SHALL leave DATA at edge k: to CHK if checksum is compiled in, else to RUN.
REQ-022 RUN: cpu_en=1, s_ready=0; cpu_en SHALL first go high at edge k+1, which is the cycle after the last w_enable pulse.
REQ-023 A load_req in RUN SHALL drop cpu_en at the next edge and move to HDR; no write SHALL occur while cpu_en=1.
REQ-024 A load_req in HDR, DATA or CHK SHALL be ignored.
REQ-025 A load_req in ERR SHALL clear err and move to HDR.
REQ-026 ERR: cpu_en=0, s_ready=0, err=1.
REQ-027 w_enable SHALL be low in every cycle not described in REQ-019.

Reset
REQ-028 While resetn=0: state=IDLE, cpu_en=0, w_enable=0, w_adrs=0, w_instruction=0, s_ready=0, err=0, counter and checksum cleared.
REQ-029 Reset mid-load SHALL abort the load immediately, including any pending write strobe, with no further writes.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: after the data words, CHK accepts one trailer word; trailer equal to the mod-2^DATA_W sum of the data words SHALL go to RUN (cpu_en high one edge later); any other value SHALL go to ERR.
REQ-031 Macro LOADER_CHECKSUM_EN undefined: the CHK state and the checksum logic SHALL be absent, and DATA SHALL go directly to RUN.

Verification
REQ-032 Reset, load_req, then host sends 3, 0x0000000E, 0x0000000F, 0x00000000 -> writes (0,0xE), (1,0xF), (2,0x0), each one cycle after acceptance; cpu_en=1 the cycle after the last write.
REQ-033 Same stream with s_valid toggled every other cycle -> identical writes in order; cpu_en stays 0 until the end.
REQ-034 Header 0, then a separate run with header 0x801 -> err=1, cpu_en=0, no w_enable pulses.
REQ-035 In RUN, pulse load_req, then load header 1, word 0xFFFFFFFF -> cpu_en drops next edge; single write (0,0xFFFFFFFF); cpu_en returns to 1.
REQ-036 Assert resetn=0 after two of three data words -> outputs at reset values, no third write, FSM in IDLE.
REQ-037 With LOADER_CHECKSUM_EN: words 0xE, 0xF, trailer 0x1D -> RUN; trailer 0x1C -> ERR with err=1.
